// File: rtl/sync_pattern_tx.sv
// Serial frame transmitter: sync word, then payload (both MSB first), then idle gap.
// Words enter through a valid/ready handshake; one line bit per clock.
module sync_pattern_tx #(
    parameter int unsigned       DATA_W       = 8,
    parameter int unsigned       SYNC_W       = 5,
    parameter logic [SYNC_W-1:0] SYNC_PATTERN = 5'b10110,
    parameter int unsigned       GAP_CYCLES   = 2,
    parameter logic              IDLE_LEVEL   = 1'b0
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [DATA_W-1:0] data_in,
    input  logic              data_valid,
    output logic              data_ready,
    output logic              seq_out,
    output logic              frame_active,
    output logic              sync_phase,
    output logic              frame_done
);
    localparam int unsigned SH_W   = SYNC_W + DATA_W;
    localparam int unsigned MAX_SD = (SYNC_W > DATA_W) ? SYNC_W : DATA_W;
    localparam int unsigned MAX_N  = (MAX_SD > GAP_CYCLES) ? MAX_SD : GAP_CYCLES;
    localparam int unsigned CNT_W  = $clog2(MAX_N + 1);

    localparam logic [CNT_W-1:0] SYNC_LAST = CNT_W'(SYNC_W - 1);
    localparam logic [CNT_W-1:0] DATA_LAST = CNT_W'(DATA_W - 1);
    localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'((GAP_CYCLES == 0) ? 0 : GAP_CYCLES - 1);
    localparam logic [CNT_W-1:0] DONE_AT   = CNT_W'((DATA_W < 2) ? 0 : DATA_W - 2);

    typedef enum logic [1:0] {S_IDLE, S_SYNC, S_DATA, S_GAP} state_t;

    state_t            state;
    logic [CNT_W-1:0]  cnt;
    logic [SH_W-1:0]   shreg;
    logic              accept;

    // Ready in idle and in the last cycle of a frame so frames can run back-to-back
    assign data_ready = !reset &&
                        ((state == S_IDLE) ||
                         (state == S_GAP && cnt == GAP_LAST) ||
                         (GAP_CYCLES == 0 && state == S_DATA && cnt == DATA_LAST));
    assign accept = data_valid && data_ready;

    // The first sync bit goes straight to the line; the rest of the frame sits in shreg
    always_ff @(posedge clock) begin
        if (reset) begin
            state        <= S_IDLE;
            cnt          <= '0;
            shreg        <= '0;
            seq_out      <= IDLE_LEVEL;
            frame_active <= 1'b0;
            sync_phase   <= 1'b0;
            frame_done   <= 1'b0;
        end else begin
            frame_done <= 1'b0;
            if (accept) begin
                state        <= S_SYNC;
                cnt          <= '0;
                shreg        <= SH_W'({SYNC_PATTERN, data_in} << 1);
                seq_out      <= SYNC_PATTERN[SYNC_W-1];
                frame_active <= 1'b1;
                sync_phase   <= 1'b1;
            end else begin
                case (state)
                    S_IDLE: begin
                        seq_out      <= IDLE_LEVEL;
                        frame_active <= 1'b0;
                        sync_phase   <= 1'b0;
                    end
                    S_SYNC: begin
                        seq_out <= shreg[SH_W-1];
                        shreg   <= shreg << 1;
                        if (cnt == SYNC_LAST) begin
                            state      <= S_DATA;
                            cnt        <= '0;
                            sync_phase <= 1'b0;
                            frame_done <= (DATA_W == 1);
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                    S_DATA: begin
                        if (cnt == DATA_LAST) begin
                            state        <= (GAP_CYCLES == 0) ? S_IDLE : S_GAP;
                            cnt          <= '0;
                            seq_out      <= IDLE_LEVEL;
                            frame_active <= 1'b0;
                        end else begin
                            seq_out    <= shreg[SH_W-1];
                            shreg      <= shreg << 1;
                            cnt        <= cnt + 1'b1;
                            frame_done <= (cnt == DONE_AT);
                        end
                    end
                    S_GAP: begin
                        if (cnt == GAP_LAST) begin
                            state <= S_IDLE;
                            cnt   <= '0;
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                    default: begin
                        state <= S_IDLE;
                        cnt   <= '0;
                    end
                endcase
            end
        end
    end
endmodule

// File: tb/tb_sync_pattern_tx.sv
// Bench for sync_pattern_tx: two instances (gap 2 and gap 0) each tracked by a
// frame-queue reference model, plus table vectors and hand-written corner sequences.
module tb_sync_pattern_tx;
    typedef struct packed {
        logic seq;
        logic act;
        logic syn;
        logic done;
    } line_t;

    typedef struct {
        logic [7:0]  word;
        logic [12:0] bits;
        int          hits;
        int          det2;
    } vec_t;

    localparam logic [4:0] SYNC_BITS = 5'b10110;

    logic       clock;
    logic       reset;
    logic       data_valid;
    logic [7:0] data_in;
    logic       rdy [2];
    logic       so  [2];
    logic       fa  [2];
    logic       sp  [2];
    logic       fd  [2];

    int checks   = 0;
    int failures = 0;
    bit chk_en   = 1'b0;
    int cyc      = 0;
    int acc_cyc  = 0;
    int done_cnt0 = 0;
    int run0      = 0;
    int max_run0  = 0;

    initial clock = 1'b0;
    always #5 clock = ~clock;
    always @(posedge clock) cyc++;

    task automatic check(input int lane, input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL lane%0d %s: got %b expected %b at %0t", lane, name, act, exp, $time);
        end
    endtask

    task automatic check_int(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    for (genvar g = 0; g < 2; g++) begin : lane
        localparam int unsigned GAP = (g == 0) ? 2 : 0;
        line_t q[$];
        line_t cur = '0;
        line_t e;

        sync_pattern_tx #(
            .DATA_W(8), .SYNC_W(5), .SYNC_PATTERN(5'b10110),
            .GAP_CYCLES(GAP), .IDLE_LEVEL(1'b0)
        ) dut (
            .clock(clock), .reset(reset), .data_in(data_in), .data_valid(data_valid),
            .data_ready(rdy[g]), .seq_out(so[g]), .frame_active(fa[g]),
            .sync_phase(sp[g]), .frame_done(fd[g])
        );

        // Reference: an accepted word becomes a list of line symbols consumed one per clock
        always @(posedge clock) begin
            if (reset) begin
                q.delete();
                cur = '0;
            end else begin
                cur = '0;
                if (q.size() != 0) begin
                    cur = q.pop_front();
                end else if (data_valid) begin
                    for (int i = 0; i < 5; i++) begin
                        e.seq = SYNC_BITS[4-i]; e.act = 1'b1; e.syn = 1'b1; e.done = 1'b0;
                        q.push_back(e);
                    end
                    for (int i = 0; i < 8; i++) begin
                        e.seq = data_in[7-i]; e.act = 1'b1; e.syn = 1'b0; e.done = (i == 7);
                        q.push_back(e);
                    end
                    for (int i = 0; i < int'(GAP); i++) begin
                        e = '0;
                        q.push_back(e);
                    end
                    cur = q.pop_front();
                end
            end
        end

        always @(negedge clock) begin
            if (chk_en) begin
                check(g, "seq_out", so[g], cur.seq);
                check(g, "frame_active", fa[g], cur.act);
                check(g, "sync_phase", sp[g], cur.syn);
                check(g, "frame_done", fd[g], cur.done);
                check(g, "data_ready", rdy[g], !reset && q.size() == 0);
            end
        end
    end

    always @(negedge clock) begin
        if (fd[0] === 1'b1) begin
            run0++;
            done_cnt0++;
            if (run0 > max_run0) max_run0 = run0;
        end else begin
            run0 = 0;
        end
    end

    task automatic send(input logic [7:0] w, input bit keep);
        int n;
        n = 0;
        data_valid = 1'b1;
        data_in    = w;
        while (!rdy[0] && n < 200) begin
            @(posedge clock); #1;
            n++;
        end
        if (n >= 200) begin
            checks++;
            failures++;
            $display("FAIL send_timeout: data_ready never rose for word %h", w);
        end
        @(posedge clock); #1;
        acc_cyc = cyc;
        if (!keep) data_valid = 1'b0;
    endtask

    vec_t       vt [5];
    logic [4:0] hist;
    logic [12:0] eb;
    logic       exp_b;
    int         nh, d0, a0, last;

    initial begin
        vt[0] = '{8'hA5, 13'b1011010100101, 1, 0};
        vt[1] = '{8'h00, 13'b1011000000000, 1, 0};
        vt[2] = '{8'hFF, 13'b1011011111111, 1, 0};
        vt[3] = '{8'hB0, 13'b1011010110000, 2, 10};
        vt[4] = '{8'h3C, 13'b1011000111100, 1, 0};

        reset = 1'b1; data_valid = 1'b0; data_in = 8'h00;
        repeat (3) @(posedge clock);
        #1 reset = 1'b0;
        chk_en = 1'b1;

        // Idle after reset
        repeat (10) begin
            @(negedge clock);
            check(0, "idle_seq", so[0], 1'b0);
            check(0, "idle_active", fa[0], 1'b0);
            check(0, "idle_ready", rdy[0], 1'b1);
        end

        // Table vectors: full line waveform per word, with a 10110 detector on the line
        for (int v = 0; v < 5; v++) begin
            send(vt[v].word, 1'b0);
            hist = '0; nh = 0; eb = vt[v].bits;
            for (int k = 1; k <= 15; k++) begin
                @(negedge clock);
                exp_b = (k <= 13) ? eb[13-k] : 1'b0;
                check(0, "tbl_seq", so[0], exp_b);
                check(0, "tbl_sync", sp[0], k <= 5);
                check(0, "tbl_done", fd[0], k == 13);
                check(0, "tbl_ready", rdy[0], k == 15);
                hist = {hist[3:0], so[0]};
                if (hist == 5'b10110) nh++;
                if (k == 5) check(0, "det_sync_end", hist == 5'b10110, 1'b1);
                if (k == vt[v].det2) check(0, "det_payload", hist == 5'b10110, 1'b1);
            end
            check_int("det_count", nh, vt[v].hits);
        end

        // Back-to-back with valid held: second sync right after the 2-cycle gap
        d0 = done_cnt0;
        send(8'hFF, 1'b1);
        a0 = acc_cyc;
        send(8'h00, 1'b1);
        data_valid = 1'b0;
        check_int("b2b_accept_spacing", acc_cyc - a0, 15);
        repeat (16) @(negedge clock);
        check_int("b2b_done_count", done_cnt0 - d0, 2);
        check_int("done_pulse_width", max_run0, 1);

        // Gap 0 lane under continuous valid: 13-cycle period, ready only with frame_done
        data_valid = 1'b1;
        last = -1;
        for (int c = 0; c < 80; c++) begin
            @(negedge clock);
            data_in = 8'($urandom);
            if (last >= 0) check(1, "gap0_ready", rdy[1], fd[1]);
            if (fd[1]) begin
                if (last >= 0) check_int("gap0_period", c - last, 13);
                last = c;
            end
        end
        data_valid = 1'b0;
        repeat (20) @(negedge clock);

        // Reset during payload bit 2 aborts the frame
        send(8'hA5, 1'b0);
        repeat (6) begin @(posedge clock); #1; end
        reset = 1'b1;
        @(posedge clock); #1;
        reset = 1'b0;
        @(negedge clock);
        check(0, "abort_seq", so[0], 1'b0);
        check(0, "abort_active", fa[0], 1'b0);
        check(0, "abort_done", fd[0], 1'b0);
        d0 = done_cnt0;
        repeat (12) @(negedge clock);
        check_int("abort_no_done", done_cnt0 - d0, 0);
        send(8'h3C, 1'b0);
        @(negedge clock);
        check(0, "restart_seq", so[0], 1'b1);
        check(0, "restart_sync", sp[0], 1'b1);
        repeat (16) @(negedge clock);

        // Random traffic with occasional resets, checked by the lane models
        for (int c = 0; c < 1500; c++) begin
            @(posedge clock); #1;
            reset      = ($urandom_range(0, 199) == 0);
            data_valid = ($urandom_range(0, 3) != 0);
            data_in    = 8'($urandom);
        end
        reset = 1'b0;
        data_valid = 1'b0;
        repeat (20) @(posedge clock);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end
endmodule
